// File: rtl/host_stream_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : host_stream_feeder_pkg
//  Description : Shared widths, types and helpers for the host stream feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package host_stream_feeder_pkg;

  // Width of one streamed byte
  localparam int BYTE_W = 8;
  // Width of the completed-byte counter
  localparam int SENT_W = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  // Larger of two integers, used to size shared phase counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous byte FIFO with occupancy count, synchronous
//                flush, and write-while-full accepted when a pop coincides.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
  import host_stream_feeder_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  byte_t             i_wr_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output byte_t             o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [FIFO_AW:0]  o_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] c_DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  byte_t                r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_empty = (r_count == '0);
  // Flush wins over both pop and push; a full FIFO still accepts a push
  // when the head is leaving in the same cycle.
  assign w_pop   = i_pop && !w_empty && !i_flush;
  assign w_push  = i_wr_en && !i_flush && (!w_full || w_pop);

  // Pointer and occupancy bookkeeping; flush clears everything in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage is left unreset; the pointers alone say which entries are valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/host_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : host_stream_feeder
//  Description : Buffers user bytes and hands them one at a time to a
//                transfer stage using a start/busy handshake, with a busy
//                timeout, inter-byte gap and completed-byte counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module host_stream_feeder
  import host_stream_feeder_pkg::*;
#(
  parameter int FIFO_AW      = 4,
  parameter int START_CYCLES = 4,
  parameter int BUSY_TIMEOUT = 255,
  parameter int GAP_CYCLES   = 2
) (
  input  logic               uc_clk,
  input  logic               uc_reset,
  input  logic               wr_en,
  input  logic [BYTE_W-1:0]  wr_data,
  input  logic               flush,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               start_transfer,
  output logic [BYTE_W-1:0]  transfer_to_host,
  input  logic               transfer_busy,
  output logic               timeout_err,
  output logic [SENT_W-1:0]  bytes_sent
);

  // One-hot state bit indices
  localparam int S_IDLE      = 0;
  localparam int S_LOAD      = 1;
  localparam int S_START     = 2;
  localparam int S_WAIT_BUSY = 3;
  localparam int S_WAIT_DONE = 4;
  localparam int S_GAP       = 5;
  localparam int NUM_STATES  = 6;

  localparam logic [NUM_STATES-1:0] c_IDLE_VEC = NUM_STATES'(1) << S_IDLE;

  // START and GAP share one phase counter; GAP_CYCLES must be at least 1
  localparam int PH_W = $clog2(max_int(START_CYCLES, GAP_CYCLES) + 1);
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [PH_W-1:0] c_START_LAST = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0] c_GAP_LAST   = PH_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] c_TO_LAST    = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [TO_W-1:0] c_TO_MAX     = '1;

  logic [NUM_STATES-1:0] r_state;
  logic [NUM_STATES-1:0] w_next;
  logic [PH_W-1:0]       r_ph_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_busy_seen;
  byte_t                 r_tx_data;
  logic                  r_timeout_err;
  logic [SENT_W-1:0]     r_bytes_sent;

  byte_t                 w_rd_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FIFO_AW:0]      w_fifo_count;
  logic                  w_start;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_to_fire;
  logic                  w_done;
  logic                  w_busy_hit;

  byte_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk       (uc_clk),
    .rst_n     (uc_reset),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_pop     (w_pop),
    .i_flush   (flush),
    .o_rd_data (w_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // A busy rise seen while start was still asserted counts as acknowledged
  assign w_busy_hit = transfer_busy || r_busy_seen;

  // State register
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) r_state <= c_IDLE_VEC;
    else           r_state <= w_next;
  end

  // Next-state logic; an illegal encoding falls back to IDLE
  always_comb begin
    w_next = '0;
    if (r_state[S_IDLE]) begin
      if (!w_fifo_empty && !transfer_busy) w_next[S_LOAD] = 1'b1;
      else                                 w_next[S_IDLE] = 1'b1;
    end else if (r_state[S_LOAD]) begin
      // Empty here only if a flush landed on the IDLE->LOAD edge
      if (w_fifo_empty) w_next[S_IDLE]  = 1'b1;
      else              w_next[S_START] = 1'b1;
    end else if (r_state[S_START]) begin
      if (r_ph_cnt == c_START_LAST) w_next[S_WAIT_BUSY] = 1'b1;
      else                          w_next[S_START]     = 1'b1;
    end else if (r_state[S_WAIT_BUSY]) begin
      if (w_busy_hit)                  w_next[S_WAIT_DONE] = 1'b1;
      else if (r_to_cnt == c_TO_LAST)  w_next[S_GAP]       = 1'b1;
      else                             w_next[S_WAIT_BUSY] = 1'b1;
    end else if (r_state[S_WAIT_DONE]) begin
      if (!transfer_busy) w_next[S_GAP]       = 1'b1;
      else                w_next[S_WAIT_DONE] = 1'b1;
    end else if (r_state[S_GAP]) begin
      if (r_ph_cnt == c_GAP_LAST) w_next[S_IDLE] = 1'b1;
      else                        w_next[S_GAP]  = 1'b1;
    end else begin
      w_next[S_IDLE] = 1'b1;
    end
  end

  // State-decoded outputs and event strobes
  always_comb begin
    w_start   = r_state[S_START];
    w_pop     = r_state[S_LOAD];
    w_load    = r_state[S_LOAD] && !w_fifo_empty;
    w_to_fire = r_state[S_WAIT_BUSY] && !w_busy_hit && (r_to_cnt == c_TO_LAST);
    w_done    = r_state[S_WAIT_DONE] && !transfer_busy;
  end

  // Phase counter for START and GAP; clears whenever the state changes
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset)                               r_ph_cnt <= '0;
    else if (w_next != r_state)                  r_ph_cnt <= '0;
    else if (r_state[S_START] || r_state[S_GAP]) r_ph_cnt <= r_ph_cnt + 1'b1;
  end

  // Busy timeout counter: zero outside WAIT_BUSY, saturates inside it
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset)                  r_to_cnt <= '0;
    else if (!r_state[S_WAIT_BUSY]) r_to_cnt <= '0;
    else if (r_to_cnt != c_TO_MAX)  r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Remember a busy rise that arrives while start is still being driven
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset)                            r_busy_seen <= 1'b0;
    else if (r_state[S_LOAD])                 r_busy_seen <= 1'b0;
    else if (r_state[S_START] && transfer_busy) r_busy_seen <= 1'b1;
  end

  // Byte register, timeout pulse and completed-byte counter
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      r_tx_data     <= '0;
      r_timeout_err <= 1'b0;
      r_bytes_sent  <= '0;
    end else begin
      if (w_load) r_tx_data <= w_rd_data;
      r_timeout_err <= w_to_fire;
      if (w_done) r_bytes_sent <= r_bytes_sent + 1'b1;
    end
  end

  assign fifo_full        = w_fifo_full;
  assign fifo_empty       = w_fifo_empty;
  assign fifo_count       = w_fifo_count;
  assign start_transfer   = w_start;
  assign transfer_to_host = r_tx_data;
  assign timeout_err      = r_timeout_err;
  assign bytes_sent       = r_bytes_sent;

endmodule
`default_nettype wire

// File: tb/tb_host_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_host_stream_feeder
//  Description : Self-checking bench for host_stream_feeder: directed
//                scenarios plus randomized traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_host_stream_feeder;

  localparam int FIFO_AW      = 4;
  localparam int DEPTH        = 16;
  localparam int START_CYCLES = 4;
  localparam int BUSY_TIMEOUT = 255;
  localparam int GAP_CYCLES   = 2;

  logic        uc_clk = 1'b0;
  logic        uc_reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        flush = 1'b0;
  logic        transfer_busy = 1'b0;
  logic        fifo_full, fifo_empty, start_transfer, timeout_err;
  logic [4:0]  fifo_count;
  logic [7:0]  transfer_to_host;
  logic [15:0] bytes_sent;

  host_stream_feeder #(
    .FIFO_AW(FIFO_AW), .START_CYCLES(START_CYCLES),
    .BUSY_TIMEOUT(BUSY_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .uc_clk(uc_clk), .uc_reset(uc_reset), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .start_transfer(start_transfer),
    .transfer_to_host(transfer_to_host), .transfer_busy(transfer_busy),
    .timeout_err(timeout_err), .bytes_sent(bytes_sent)
  );

  always #5 uc_clk = ~uc_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MD_IDLE = 0, MD_LOAD = 1, MD_START = 2, MD_WAITB = 3, MD_WAITD = 4, MD_GAP = 5;
  int          m_mode = MD_IDLE;
  logic [7:0]  m_q[$];
  logic [7:0]  m_data = '0;
  int          m_left = 0;
  int          m_wait = 0;
  bit          m_seen = 0;
  bit          m_to = 0;
  logic [15:0] m_sent = '0;

  initial begin : model
    int  sz0;
    bit  pop;
    forever begin
      @(posedge uc_clk or negedge uc_reset);
      if (!uc_reset) begin
        m_mode = MD_IDLE; m_q.delete(); m_data = '0; m_left = 0; m_wait = 0;
        m_seen = 0; m_to = 0; m_sent = '0;
      end else begin
        sz0  = m_q.size();
        pop  = 0;
        m_to = 0;
        case (m_mode)
          MD_IDLE:  if (sz0 > 0 && !transfer_busy) m_mode = MD_LOAD;
          MD_LOAD:  if (sz0 == 0) m_mode = MD_IDLE;
                    else begin
                      m_data = m_q[0]; pop = 1; m_mode = MD_START;
                      m_left = START_CYCLES; m_seen = 0;
                    end
          MD_START: begin
                      m_seen = m_seen | transfer_busy;
                      m_left--;
                      if (m_left == 0) begin m_mode = MD_WAITB; m_wait = 0; end
                    end
          MD_WAITB: if (transfer_busy || m_seen) m_mode = MD_WAITD;
                    else begin
                      m_wait++;
                      if (m_wait == BUSY_TIMEOUT) begin
                        m_mode = MD_GAP; m_left = GAP_CYCLES; m_to = 1;
                      end
                    end
          MD_WAITD: if (!transfer_busy) begin
                      m_mode = MD_GAP; m_left = GAP_CYCLES; m_sent = m_sent + 16'd1;
                    end
          default:  begin m_left--; if (m_left == 0) m_mode = MD_IDLE; end
        endcase
        if (flush) m_q.delete();
        else begin
          if (pop) void'(m_q.pop_front());
          if (wr_en && (sz0 < DEPTH || pop)) m_q.push_back(wr_data);
        end
      end
    end
  end

  // ---------------- compare process and event monitor ----------------
  bit          cmp_en = 0;
  int          cyc = 0;
  bit          mon_prev = 0;
  int          run_len = 0, last_run = 0, n_runs = 0, fall_cyc = 0, to_cyc = 0, n_to = 0;
  logic [7:0]  sent_log[$];

  initial begin : compare
    forever begin
      @(negedge uc_clk);
      cyc++;
      if (start_transfer) begin
        if (!mon_prev) begin n_runs++; run_len = 0; sent_log.push_back(transfer_to_host); end
        run_len++;
      end else if (mon_prev) begin
        last_run = run_len; fall_cyc = cyc;
      end
      if (timeout_err) begin n_to++; to_cyc = cyc; end
      mon_prev = start_transfer;
      if (cmp_en) begin
        chk("start_transfer", start_transfer, (m_mode == MD_START));
        chk("transfer_to_host", transfer_to_host, m_data);
        chk("fifo_count", fifo_count, m_q.size());
        chk("fifo_empty", fifo_empty, (m_q.size() == 0));
        chk("fifo_full", fifo_full, (m_q.size() == DEPTH));
        chk("timeout_err", timeout_err, m_to);
        chk("bytes_sent", bytes_sent, m_sent);
      end
    end
  end

  // ---------------- transfer-stage responder ----------------
  int resp_mode = 2;      // 0 handshake, 1 stuck high, 2 stuck low
  bit resp_rand = 0;
  int fix_rise = 2, fix_hold = 5;
  int resp_cnt = 0, resp_hold = 0;
  bit resp_prev = 0;

  initial begin : responder
    int rise, hold;
    forever begin
      @(posedge uc_clk); #1;
      if (resp_mode == 0) begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == resp_hold) transfer_busy = 1'b1;
          if (resp_cnt == 0)         transfer_busy = 1'b0;
        end else if (start_transfer && !resp_prev) begin
          rise = fix_rise; hold = fix_hold;
          if (resp_rand) begin
            rise = $urandom_range(1, 6);
            hold = $urandom_range(1, 6);
            if ($urandom_range(0, 15) == 0) rise = 0;
          end
          if (rise > 0) begin resp_cnt = rise + hold; resp_hold = hold; end
        end
      end else if (resp_mode == 1) begin
        transfer_busy = 1'b1; resp_cnt = 0;
      end else begin
        transfer_busy = 1'b0; resp_cnt = 0;
      end
      resp_prev = start_transfer;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge uc_clk); #1;
  endtask

  task automatic do_reset();
    uc_reset = 1'b0; wr_en = 1'b0; flush = 1'b0;
    tick();
    cmp_en = 1;
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_start", start_transfer, 0);
    chk("rst_sent", bytes_sent, 0);
    tick();
    uc_reset = 1'b1;
    tick();
    sent_log.delete();
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (!(m_mode == MD_IDLE && m_q.size() == 0 && resp_cnt == 0) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL wait_quiet: got timeout want idle after %0d cycles", budget);
    end
    repeat (3) tick();
  endtask

  task automatic wait_start(input logic lvl, input int budget);
    int n = 0;
    while (start_transfer !== lvl && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL wait_start: got timeout want start=%0d", lvl);
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin : stim
    int lat, runs0, to0;
    tick();

    // Single byte handshake
    do_reset();
    resp_mode = 0; resp_rand = 0; fix_rise = 2; fix_hold = 5;
    write_byte(8'hA5);
    lat = 1;
    while (!start_transfer && lat < 20) begin tick(); lat++; end
    chk("latency", lat, 3);
    wait_quiet(200);
    chk("single_run_len", last_run, 4);
    chk("single_data", transfer_to_host, 8'hA5);
    chk("single_sent", bytes_sent, 1);
    chk("single_log", sent_log.size() == 1 ? sent_log[0] : 8'hFF, 8'hA5);

    // Full FIFO with busy stuck high, then drain in order
    do_reset();
    resp_mode = 1; transfer_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(i));
      if (i == 15) chk("full_at_16", fifo_full, 1);
    end
    chk("full_count", fifo_count, 16);
    chk("full_flag", fifo_full, 1);
    chk("full_runs_blocked", n_runs, 0 + n_runs - sent_log.size());
    resp_mode = 0; transfer_busy = 1'b0;
    wait_quiet(2000);
    chk("full_sent", bytes_sent, 16);
    chk("full_log_size", sent_log.size(), 16);
    for (int i = 0; i < 16 && i < sent_log.size(); i++) chk("full_order", sent_log[i], i);

    // Timeout with busy held low
    do_reset();
    resp_mode = 2; transfer_busy = 1'b0;
    to0 = n_to;
    write_byte(8'h3C);
    wait_quiet(1000);
    chk("to_pulses", n_to - to0, 1);
    chk("to_delay", to_cyc - fall_cyc, 255);
    chk("to_sent", bytes_sent, 0);
    chk("to_empty", fifo_empty, 1);
    runs0 = n_runs;
    repeat (20) tick();
    chk("to_idle", n_runs - runs0, 0);

    // Flush during WAIT_DONE with five bytes queued
    do_reset();
    resp_mode = 0; fix_rise = 2; fix_hold = 10;
    runs0 = n_runs;
    for (int i = 0; i < 5; i++) write_byte(8'h40 + 8'(i));
    wait_start(1'b1, 50);
    wait_start(1'b0, 50);
    tick();
    chk("flush_pre_count", fifo_count, 4);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_count", fifo_count, 0);
    wait_quiet(500);
    chk("flush_sent", bytes_sent, 1);
    chk("flush_runs", n_runs - runs0, 1);

    // Reset while start_transfer is high
    write_byte(8'h77);
    write_byte(8'h78);
    wait_start(1'b1, 50);
    tick();
    uc_reset = 1'b0;
    #1;
    chk("mid_rst_start", start_transfer, 0);
    chk("mid_rst_data", transfer_to_host, 0);
    chk("mid_rst_to", timeout_err, 0);
    chk("mid_rst_sent", bytes_sent, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_empty", fifo_empty, 1);
    chk("mid_rst_full", fifo_full, 0);
    tick();
    uc_reset = 1'b1;
    runs0 = n_runs;
    repeat (30) tick();
    chk("post_rst_runs", n_runs - runs0, 0);

    // Write during LOAD while full
    do_reset();
    resp_mode = 1; transfer_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    chk("wl_full", fifo_full, 1);
    resp_mode = 0; fix_rise = 2; fix_hold = 3; transfer_busy = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    chk("wl_count", fifo_count, 16);
    chk("wl_started", start_transfer, 1);
    wait_quiet(3000);
    chk("wl_sent", bytes_sent, 17);
    chk("wl_log_size", sent_log.size(), 17);
    if (sent_log.size() == 17) begin
      chk("wl_first", sent_log[0], 8'h20);
      chk("wl_last", sent_log[16], 8'h55);
    end

    // Randomized traffic against the model
    do_reset();
    resp_mode = 0; resp_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 255) == 0);
      tick();
    end
    wr_en = 1'b0; flush = 1'b0;
    wait_quiet(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/host_stream_feeder.md
HOST_STREAM_FEEDER -- requirements
Module: host_stream_feeder

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning log2 of FIFO depth (16 bytes).
REQ-002 SHALL have parameter START_CYCLES, default 4, meaning cycles start_transfer is held high per byte (legal range 3..15).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 255, meaning max cycles to wait for transfer_busy to rise.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles between bytes.
REQ-005 SHALL have port uc_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port uc_reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port wr_en, input, 1 bit: user byte write strobe.
REQ-008 SHALL have port wr_data, input, 8 bits: user byte.
REQ-009 SHALL have port flush, input, 1 bit: synchronous FIFO clear.
REQ-010 SHALL have port fifo_full, output, 1 bit: FIFO full.
REQ-011 SHALL have port fifo_empty, output, 1 bit: FIFO empty.
REQ-012 SHALL have port fifo_count, output, FIFO_AW+1 bits: FIFO occupancy.
REQ-013 SHALL have port start_transfer, output, 1 bit: to the transfer stage.
REQ-014 SHALL have port transfer_to_host, output, 8 bits: byte to the transfer stage.
REQ-015 SHALL have port transfer_busy, input, 1 bit: from the transfer stage.
REQ-016 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when busy never rose.
REQ-017 SHALL have port bytes_sent, output, 16 bits: completed-byte counter.

Function
REQ-018 SHALL write wr_data to the FIFO when wr_en=1, fifo_full=0 and flush=0; a write while full is dropped, with no state change.
REQ-019 SHALL accept a simultaneous write and pop when full, leaving fifo_count unchanged.
REQ-020 SHALL, on flush=1, zero the pointers and count in the same cycle; flush overrides a same-cycle write; a byte already in flight finishes normally.
REQ-021 SHALL implement the FSM states IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE and GAP, with a one-hot state register.
REQ-022 IDLE SHALL go to LOAD when fifo_empty=0 and transfer_busy=0; a high transfer_busy (e.g. from inbound traffic) blocks the start.
REQ-023 LOAD SHALL pop the FIFO head into the transfer_to_host register, then go to START; latency from first write into an empty, idle block to start_transfer=1 is 3 cycles.
REQ-024 START SHALL hold start_transfer=1 for exactly START_CYCLES cycles, then deassert it and go to WAIT_BUSY; the counter then clears.
REQ-025 WAIT_BUSY SHALL go to WAIT_DONE on transfer_busy=1 (a rise already seen during START counts); after BUSY_TIMEOUT cycles without it, it SHALL pulse timeout_err for 1 cycle, discard the byte and go to GAP.
REQ-026 WAIT_DONE SHALL go to GAP on transfer_busy=0 and increment bytes_sent by 1 (wrapping at 16'hFFFF to 0).
REQ-027 GAP SHALL wait GAP_CYCLES cycles, then go to IDLE.
REQ-028 transfer_to_host SHALL remain stable from LOAD until the next LOAD.
REQ-029 The timeout counter SHALL saturate rather than wrap, and SHALL clear on entry to WAIT_BUSY.

Reset
REQ-030 SHALL, on uc_reset=0 at any time including mid-transfer, immediately set: state=IDLE, start_transfer=0, transfer_to_host=0, timeout_err=0, bytes_sent=0, fifo_count=0, fifo_empty=1, fifo_full=0, with all counters zero.
REQ-031 SHALL leave FIFO storage contents uninitialised; the pointers alone define validity.

Structure
REQ-032 SHALL take the byte width (UC_DATAIN width) and the shared command/width constants from the common define.v include; the FSM state indices SHALL be local parameters.
REQ-033 SHALL place the FIFO in one sub-module, byte_fifo (synchronous, same clock and reset, parameter FIFO_AW); the FSM and counters SHALL live in host_stream_feeder.

Verification
REQ-034 SHALL verify single byte: write 8'hA5 into an empty block, model raises busy 2 cycles after start and drops it 5 cycles later -> start_transfer high exactly 4 cycles, transfer_to_host=8'hA5, bytes_sent=1.
REQ-035 SHALL verify full FIFO: write 17 bytes 0x00..0x10 with busy stuck high -> fifo_full=1 at 16, byte 0x10 dropped, fifo_count=16; then release busy -> 0x00..0x0F sent in order, bytes_sent=16.
REQ-036 SHALL verify timeout: write 8'h3C with busy held low -> timeout_err pulses once 255 cycles after start deasserts, byte discarded, bytes_sent=0, FSM back in IDLE.
REQ-037 SHALL verify flush mid-transfer: with 5 bytes queued, assert flush during WAIT_DONE -> current byte completes (bytes_sent=1), fifo_count=0, no further start_transfer.
REQ-038 SHALL verify reset mid-START: deassert uc_reset while start_transfer=1 -> start_transfer=0 and all outputs at reset values in the same cycle; after release an empty FIFO yields no activity.
REQ-039 SHALL verify simultaneous write and pop: fifo_count=16 and a write in the LOAD cycle -> count stays 16 and the new byte is sent last.
